// File: rtl/audio_axis_pkg.sv
// Shared types and constants for the stereo AXI-Stream audio path.
package audio_axis_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        OUT  = 2'd2,
        MUTE = 2'd3
    } state_e;

    localparam int DESYNC_CNT_W = 8;

    // Sliced down to the sample width at the point of use.
    localparam logic [63:0] ZERO_SAMPLE = 64'd0;

endpackage

// File: rtl/axis_hold_reg.sv
// One-entry per-channel sample holder: captures on i_load, empties on i_clr (clear wins).
// Contents visible on o_* the cycle after capture; no flow control of its own.
module axis_hold_reg #(
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_clr,
    input  logic [DATA_WIDTH-1:0] i_dat,
    input  logic                  i_user,
    output logic                  o_vld,
    output logic [DATA_WIDTH-1:0] o_dat,
    output logic                  o_user
);

    logic                  r_vld;
    logic                  r_user;
    logic [DATA_WIDTH-1:0] r_dat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld  <= 1'b0;
            r_user <= 1'b0;
            r_dat  <= '0;
        end else if (i_clr) begin
            r_vld <= 1'b0;
        end else if (i_load) begin
            r_vld  <= 1'b1;
            r_dat  <= i_dat;
            r_user <= i_user;
        end
    end

    assign o_vld  = r_vld;
    assign o_dat  = r_dat;
    assign o_user = r_user;

endmodule

// File: rtl/axis_stereo_aligner.sv
// Pairs one left and one right sample into a lock-step stereo frame for the DAC pair.
// Frame valid one cycle after the second sample lands; s_tready stays low while a frame drains.
module axis_stereo_aligner
    import audio_axis_pkg::*;
#(
    parameter int DATA_WIDTH   = 24,
    parameter int SKEW_TIMEOUT = 64,
    parameter int IDLE_TIMEOUT = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata_l,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata_r,
    input  logic                    s_axis_tvalid_l,
    input  logic                    s_axis_tvalid_r,
    output logic                    s_axis_tready_l,
    output logic                    s_axis_tready_r,
    input  logic                    s_axis_tuser_l,
    input  logic                    s_axis_tuser_r,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata_l,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata_r,
    output logic                    m_axis_tvalid_l,
    output logic                    m_axis_tvalid_r,
    input  logic                    m_axis_tready_l,
    input  logic                    m_axis_tready_r,
    output logic                    m_axis_tuser_l,
    output logic                    m_axis_tuser_r,
    output logic                    underrun,
    output logic [DESYNC_CNT_W-1:0] desync_count
);

    localparam int SW = (SKEW_TIMEOUT > 1) ? $clog2(SKEW_TIMEOUT) : 1;
    localparam int IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [SW-1:0] SKEW_LAST = SW'(SKEW_TIMEOUT - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

    state_e                  r_state;
    logic                    r_started;
    logic                    r_underrun;
    logic [SW-1:0]           r_skew;
    logic [IW-1:0]           r_idle;
    logic [DESYNC_CNT_W-1:0] r_desync;
    logic                    r_mvld_l, r_mvld_r;
    logic                    r_muser_l, r_muser_r;
    logic [DATA_WIDTH-1:0]   r_mdat_l, r_mdat_r;

    logic                  w_hold_vld_l, w_hold_vld_r;
    logic                  w_hold_user_l, w_hold_user_r;
    logic [DATA_WIDTH-1:0] w_hold_dat_l, w_hold_dat_r;
    logic                  w_rdy_l, w_rdy_r, w_acc_l, w_acc_r, w_hs_l, w_hs_r;
    logic                  w_pair, w_drop, w_clr, w_mute_go;
    logic                  w_skew_exp, w_idle_exp, w_out_done;

    assign w_rdy_l    = enable & r_started & ~w_hold_vld_l & (r_state != OUT);
    assign w_rdy_r    = enable & r_started & ~w_hold_vld_r & (r_state != OUT);
    assign w_acc_l    = s_axis_tvalid_l & w_rdy_l;
    assign w_acc_r    = s_axis_tvalid_r & w_rdy_r;
    assign w_hs_l     = r_mvld_l & m_axis_tready_l;
    assign w_hs_r     = r_mvld_r & m_axis_tready_r;
    assign w_skew_exp = (r_skew == SKEW_LAST);
    assign w_idle_exp = (r_idle == IDLE_LAST);
    assign w_out_done = (~r_mvld_l | w_hs_l) & (~r_mvld_r | w_hs_r);

    // A partner arriving on the timeout cycle still completes the frame.
    assign w_pair    = (w_acc_l | w_hold_vld_l) & (w_acc_r | w_hold_vld_r) & (w_acc_l | w_acc_r);
    assign w_drop    = (r_state == WAIT) & enable & ~w_pair & (w_skew_exp | w_idle_exp);
    assign w_clr     = w_pair | w_drop | ~enable;
    assign w_mute_go = enable & ~w_pair & w_idle_exp &
                       (((r_state == IDLE) & ~w_acc_l & ~w_acc_r) | (r_state == WAIT));

    axis_hold_reg #(.DATA_WIDTH(DATA_WIDTH)) u_hold_l (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_acc_l & ~w_pair),
        .i_clr  (w_clr),
        .i_dat  (s_axis_tdata_l),
        .i_user (s_axis_tuser_l),
        .o_vld  (w_hold_vld_l),
        .o_dat  (w_hold_dat_l),
        .o_user (w_hold_user_l)
    );

    axis_hold_reg #(.DATA_WIDTH(DATA_WIDTH)) u_hold_r (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_acc_r & ~w_pair),
        .i_clr  (w_clr),
        .i_dat  (s_axis_tdata_r),
        .i_user (s_axis_tuser_r),
        .o_vld  (w_hold_vld_r),
        .o_dat  (w_hold_dat_r),
        .o_user (w_hold_user_r)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_started  <= 1'b0;
            r_underrun <= 1'b0;
            r_skew     <= '0;
            r_idle     <= '0;
            r_desync   <= '0;
            r_mvld_l   <= 1'b0;
            r_mvld_r   <= 1'b0;
            r_muser_l  <= 1'b0;
            r_muser_r  <= 1'b0;
            r_mdat_l   <= '0;
            r_mdat_r   <= '0;
        end else begin
            r_started <= 1'b1;
            if (w_hs_l) r_mvld_l <= 1'b0;
            if (w_hs_r) r_mvld_r <= 1'b0;
            if (!w_idle_exp) r_idle <= r_idle + 1'b1;

            if (w_pair) begin
                r_state    <= OUT;
                r_idle     <= '0;
                r_underrun <= 1'b0;
                r_mvld_l   <= 1'b1;
                r_mvld_r   <= 1'b1;
                r_mdat_l   <= w_hold_vld_l ? w_hold_dat_l  : s_axis_tdata_l;
                r_muser_l  <= w_hold_vld_l ? w_hold_user_l : s_axis_tuser_l;
                r_mdat_r   <= w_hold_vld_r ? w_hold_dat_r  : s_axis_tdata_r;
                r_muser_r  <= w_hold_vld_r ? w_hold_user_r : s_axis_tuser_r;
            end else begin
                case (r_state)
                    IDLE, MUTE: begin
                        if (!enable) begin
                            r_state <= IDLE;
                        end else if (w_acc_l | w_acc_r) begin
                            r_state <= WAIT;
                            r_skew  <= '0;
                            if (w_idle_exp && r_state == IDLE) r_idle <= '0;
                        end
                    end
                    WAIT: begin
                        if (!enable) begin
                            r_state <= IDLE;
                        end else if (w_drop) begin
                            r_state <= IDLE;
                            if (r_desync != '1) r_desync <= r_desync + 1'b1;
                        end else begin
                            r_skew <= r_skew + 1'b1;
                        end
                    end
                    OUT: begin
                        if (w_out_done) r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase

                // Only the first expiry of an underrun emits a zero frame.
                if (w_mute_go) begin
                    r_state <= MUTE;
                    if (!r_underrun) begin
                        r_underrun <= 1'b1;
                        r_mvld_l   <= 1'b1;
                        r_mvld_r   <= 1'b1;
                        r_mdat_l   <= ZERO_SAMPLE[DATA_WIDTH-1:0];
                        r_mdat_r   <= ZERO_SAMPLE[DATA_WIDTH-1:0];
                        r_muser_l  <= 1'b0;
                        r_muser_r  <= 1'b0;
                    end
                end
            end
        end
    end

    assign s_axis_tready_l = w_rdy_l;
    assign s_axis_tready_r = w_rdy_r;
    assign m_axis_tdata_l  = r_mdat_l;
    assign m_axis_tdata_r  = r_mdat_r;
    assign m_axis_tvalid_l = r_mvld_l;
    assign m_axis_tvalid_r = r_mvld_r;
    assign m_axis_tuser_l  = r_muser_l;
    assign m_axis_tuser_r  = r_muser_r;
    assign underrun        = r_underrun;
    assign desync_count    = r_desync;

endmodule

// File: tb/tb_axis_stereo_aligner.sv
// Randomized and directed bench for axis_stereo_aligner against a frame-level pairing model.
module tb_axis_stereo_aligner;

    localparam int DW   = 24;
    localparam int SKEW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [DW-1:0] s_axis_tdata_l, s_axis_tdata_r;
    logic          s_axis_tvalid_l, s_axis_tvalid_r;
    logic          s_axis_tready_l, s_axis_tready_r;
    logic          s_axis_tuser_l, s_axis_tuser_r;
    logic [DW-1:0] m_axis_tdata_l, m_axis_tdata_r;
    logic          m_axis_tvalid_l, m_axis_tvalid_r;
    logic          m_axis_tready_l, m_axis_tready_r;
    logic          m_axis_tuser_l, m_axis_tuser_r;
    logic          underrun;
    logic [7:0]    desync_count;

    always #10 clk = ~clk;

    axis_stereo_aligner #(.DATA_WIDTH(DW), .SKEW_TIMEOUT(SKEW), .IDLE_TIMEOUT(4096)) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .s_axis_tdata_l  (s_axis_tdata_l),
        .s_axis_tdata_r  (s_axis_tdata_r),
        .s_axis_tvalid_l (s_axis_tvalid_l),
        .s_axis_tvalid_r (s_axis_tvalid_r),
        .s_axis_tready_l (s_axis_tready_l),
        .s_axis_tready_r (s_axis_tready_r),
        .s_axis_tuser_l  (s_axis_tuser_l),
        .s_axis_tuser_r  (s_axis_tuser_r),
        .m_axis_tdata_l  (m_axis_tdata_l),
        .m_axis_tdata_r  (m_axis_tdata_r),
        .m_axis_tvalid_l (m_axis_tvalid_l),
        .m_axis_tvalid_r (m_axis_tvalid_r),
        .m_axis_tready_l (m_axis_tready_l),
        .m_axis_tready_r (m_axis_tready_r),
        .m_axis_tuser_l  (m_axis_tuser_l),
        .m_axis_tuser_r  (m_axis_tuser_r),
        .underrun        (underrun),
        .desync_count    (desync_count)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: pending orphan per channel, expected output frames per channel.
    bit          started, en_cur;
    bit          pend_l, pend_r;
    logic [DW:0] hold_l, hold_r;
    int          t_l, t_r, cyc, desync_exp;
    logic [DW:0] q_l[$];
    logic [DW:0] q_r[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit base_rdy(input bit pend);
        return started && !pend && q_l.size() == 0 && q_r.size() == 0;
    endfunction

    task automatic step(input bit vl, input logic [DW-1:0] dl, input bit ul,
                        input bit vr, input logic [DW-1:0] dr, input bit ur,
                        input bit rl, input bit rr, input bit en_new);
        bit ok_l, ok_r, al, ar;
        logic [DW:0] fl, fr;
        ok_l = base_rdy(pend_l);
        ok_r = base_rdy(pend_r);
        chk("s_tready_l", 32'(s_axis_tready_l), 32'(ok_l & en_cur));
        chk("s_tready_r", 32'(s_axis_tready_r), 32'(ok_r & en_cur));
        chk("m_tvalid_l", 32'(m_axis_tvalid_l), 32'(q_l.size() != 0));
        chk("m_tvalid_r", 32'(m_axis_tvalid_r), 32'(q_r.size() != 0));
        chk("desync", 32'(desync_count), 32'(desync_exp));

        s_axis_tvalid_l = vl; s_axis_tdata_l = dl; s_axis_tuser_l = ul;
        s_axis_tvalid_r = vr; s_axis_tdata_r = dr; s_axis_tuser_r = ur;
        m_axis_tready_l = rl; m_axis_tready_r = rr;
        enable = en_new; en_cur = en_new;

        if (m_axis_tvalid_l && rl && q_l.size() != 0)
            chk("frame_l", 32'({m_axis_tuser_l, m_axis_tdata_l}), 32'(q_l.pop_front()));
        if (m_axis_tvalid_r && rr && q_r.size() != 0)
            chk("frame_r", 32'({m_axis_tuser_r, m_axis_tdata_r}), 32'(q_r.pop_front()));

        al = vl && ok_l && en_new;
        ar = vr && ok_r && en_new;
        fl = {ul, dl};
        fr = {ur, dr};
        if ((al || pend_l) && (ar || pend_r) && (al || ar)) begin
            q_l.push_back(al ? fl : hold_l);
            q_r.push_back(ar ? fr : hold_r);
            pend_l = 0;
            pend_r = 0;
        end else begin
            if (al) begin pend_l = 1; hold_l = fl; t_l = cyc; end
            if (ar) begin pend_r = 1; hold_r = fr; t_r = cyc; end
            if (!en_new) begin pend_l = 0; pend_r = 0; end
            if (pend_l && cyc - t_l == SKEW) begin
                pend_l = 0;
                if (desync_exp < 255) desync_exp++;
            end
            if (pend_r && cyc - t_r == SKEW) begin
                pend_r = 0;
                if (desync_exp < 255) desync_exp++;
            end
        end
        @(negedge clk);
        cyc++;
        started = 1;
    endtask

    task automatic idle(input bit rl, input bit rr);
        step(0, '0, 0, 0, '0, 0, rl, rr, 1);
    endtask

    task automatic pair(input logic [DW-1:0] dl, input bit ul, input logic [DW-1:0] dr, input bit ur,
                        input bit rl, input bit rr);
        step(1, dl, ul, 1, dr, ur, rl, rr, 1);
    endtask

    task automatic model_reset();
        q_l.delete(); q_r.delete();
        pend_l = 0; pend_r = 0;
        desync_exp = 0;
        started = 0;
    endtask

    initial begin
        int sil_l, sil_r, k, extra;
        rst = 1'b1; enable = 1'b1; en_cur = 1'b1;
        s_axis_tvalid_l = 0; s_axis_tvalid_r = 0; s_axis_tdata_l = '0; s_axis_tdata_r = '0;
        s_axis_tuser_l = 0; s_axis_tuser_r = 0; m_axis_tready_l = 1; m_axis_tready_r = 1;
        cyc = 0; t_l = 0; t_r = 0; hold_l = '0; hold_r = '0;
        model_reset();

        repeat (3) @(negedge clk);
        chk("rst_tvalid_l", 32'(m_axis_tvalid_l), 0);
        chk("rst_tvalid_r", 32'(m_axis_tvalid_r), 0);
        chk("rst_tdata_l", 32'(m_axis_tdata_l), 0);
        chk("rst_tuser_r", 32'(m_axis_tuser_r), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_tready_l", 32'(s_axis_tready_l), 0);
        rst = 1'b0;
        idle(1, 1);

        // Aligned pair, same cycle.
        pair(24'h123456, 1, 24'hFEDCBA, 0, 1, 1);
        chk("align_vld_l", 32'(m_axis_tvalid_l), 1);
        chk("align_dat_l", 32'(m_axis_tdata_l), 32'h123456);
        chk("align_dat_r", 32'(m_axis_tdata_r), 32'hFEDCBA);
        chk("align_desync", 32'(desync_count), 0);
        idle(1, 1);

        // Skewed: R ten cycles after L.
        step(1, 24'hA5A5A5, 0, 0, '0, 0, 1, 1, 1);
        repeat (9) idle(1, 1);
        step(0, '0, 0, 1, 24'h5A5A5A, 1, 1, 1, 1);
        chk("skew_vld_r", 32'(m_axis_tvalid_r), 1);
        chk("skew_dat_l", 32'(m_axis_tdata_l), 32'hA5A5A5);
        chk("skew_user_r", 32'(m_axis_tuser_r), 1);
        idle(1, 1);
        idle(1, 1);

        // Enable drop discards a held sample without counting it.
        step(1, 24'h0BAD00, 1, 0, '0, 0, 1, 1, 1);
        repeat (3) step(0, '0, 0, 0, '0, 0, 1, 1, 0);
        idle(1, 1);
        pair(24'h000111, 0, 24'h000222, 0, 1, 1);
        chk("en_frame_l", 32'(m_axis_tdata_l), 32'h000111);
        idle(1, 1);

        // Single orphan.
        step(1, 24'h777777, 0, 0, '0, 0, 1, 1, 1);
        repeat (SKEW) idle(1, 1);
        chk("orphan_desync", 32'(desync_count), 1);
        idle(1, 1);

        // Random traffic with silences long enough to create orphans.
        sil_l = 0; sil_r = 0;
        for (int i = 0; i < 3000; i++) begin
            if (sil_l > 0) sil_l--; else if ($urandom_range(0, 99) == 0) sil_l = $urandom_range(30, 90);
            if (sil_r > 0) sil_r--; else if ($urandom_range(0, 99) == 0) sil_r = $urandom_range(30, 90);
            step(sil_l == 0 && $urandom_range(0, 2) == 0, DW'($urandom), 1'($urandom),
                 sil_r == 0 && $urandom_range(0, 2) == 0, DW'($urandom), 1'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1);
        end
        repeat (70) idle(1, 1);

        // Saturation of the orphan counter, with periodic frames to keep underrun away.
        for (int i = 0; i < 300; i++) begin
            if (i % 40 == 0) begin
                pair(DW'($urandom), 0, DW'($urandom), 1, 1, 1);
                idle(1, 1);
            end
            step(1, DW'($urandom), 0, 0, '0, 0, 1, 1, 1);
            repeat (SKEW) idle(1, 1);
        end
        idle(1, 1);
        chk("desync_sat", 32'(desync_count), 255);

        // Back-pressure on the right channel only.
        pair(24'h0C0C0C, 0, 24'h0D0D0D, 1, 1, 0);
        repeat (20) step(1, DW'($urandom), 0, 1, DW'($urandom), 0, 1, 0, 1);
        chk("bp_dat_r", 32'(m_axis_tdata_r), 32'h0D0D0D);
        chk("bp_vld_l", 32'(m_axis_tvalid_l), 0);
        chk("bp_rdy_r", 32'(s_axis_tready_r), 0);
        idle(1, 1);
        idle(1, 1);

        // Underrun: zero frame exactly 4096 edges after the last OUT entry.
        pair(24'h111111, 1, 24'h222222, 1, 1, 1);
        idle(1, 1);
        k = 1;
        while (!m_axis_tvalid_l && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk("mute_latency", 32'(k), 4096);
        chk("mute_vld_r", 32'(m_axis_tvalid_r), 1);
        chk("mute_dat_l", 32'(m_axis_tdata_l), 0);
        chk("mute_dat_r", 32'(m_axis_tdata_r), 0);
        chk("mute_user_l", 32'(m_axis_tuser_l), 0);
        chk("mute_user_r", 32'(m_axis_tuser_r), 0);
        chk("mute_flag", 32'(underrun), 1);
        extra = 0;
        @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            if (m_axis_tvalid_l || m_axis_tvalid_r) extra++;
            @(negedge clk);
        end
        chk("mute_single", 32'(extra), 0);
        chk("mute_sticky", 32'(underrun), 1);
        pair(24'h333333, 0, 24'h444444, 0, 1, 1);
        chk("unmute_flag", 32'(underrun), 0);
        chk("unmute_dat_r", 32'(m_axis_tdata_r), 32'h444444);
        idle(1, 1);

        // Async reset while a frame is stalled in OUT.
        pair(24'h555555, 1, 24'h666666, 1, 0, 0);
        #3 rst = 1'b1;
        #1;
        chk("arst_vld_l", 32'(m_axis_tvalid_l), 0);
        chk("arst_vld_r", 32'(m_axis_tvalid_r), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle(1, 1);
        pair(24'h0ABCDE, 0, 24'h0EDCBA, 1, 1, 1);
        chk("post_rst_l", 32'(m_axis_tdata_l), 32'h0ABCDE);
        chk("post_rst_r", 32'({m_axis_tuser_r, m_axis_tdata_r}), 32'h10EDCBA);
        idle(1, 1);
        idle(1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
